// File: rtl/rom_loader.sv
// Streams LENGTH bytes into CPU ROM starting at BASE_ADDR and holds the CPU in reset until the load completes.
// Optional trailing-checksum verification is enabled with `define ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter logic [16:0] LENGTH     = 17'h0C000,
    parameter int          AUTO_START = 1
) (
    input  logic        clk_12m,
    input  logic        rst,
    input  logic        load_start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] rom_write_addr,
    output logic [7:0]  rom_write_data,
    output logic        rom_write_en,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;

    localparam logic [16:0] LAST       = LENGTH - 17'd1;
    localparam logic        START_INIT = (AUTO_START != 0);

    state_t      state;
    logic [16:0] cnt;
    logic        start_pend;
    logic        xfer;

    assign xfer = in_valid & in_ready;

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] ck_total;
    logic       error_q;
    assign ck_total = sum + in_data;
    assign error    = error_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk_12m or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            start_pend     <= START_INIT;
            in_ready       <= 1'b0;
            rom_write_en   <= 1'b0;
            rom_write_addr <= BASE_ADDR;
            rom_write_data <= 8'h00;
            cpu_rst        <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum            <= 8'h00;
            error_q        <= 1'b0;
`endif
        end else begin
            rom_write_en <= 1'b0;
            start_pend   <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (load_start || start_pend) begin
                        state    <= LOAD;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        cpu_rst  <= 1'b1;
                        done     <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
                        sum      <= 8'h00;
                        error_q  <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        rom_write_en   <= 1'b1;
                        rom_write_data <= in_data;
                        rom_write_addr <= BASE_ADDR + cnt[15:0];
                        cnt            <= cnt + 17'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
                        sum            <= sum + in_data;
                        if (cnt == LAST)
                            state <= CHECK;
`else
                        if (cnt == LAST)
                            in_ready <= 1'b0;
`endif
                    end
`ifndef ROM_LOADER_CHECKSUM_EN
                    // one drain cycle so cpu_rst falls only after the last strobe is seen
                    else if (cnt == LENGTH) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        cpu_rst <= 1'b0;
                        done    <= 1'b1;
                    end
`endif
                end
`ifdef ROM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (ck_total == 8'h00) begin
                            state   <= DONE;
                            cpu_rst <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state   <= ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
